// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder with byte/halfword/word lanes and fixed read latency
//   clock, reset            : rising-edge clock, synchronous active-high reset
//   req_valid/req_write     : request strobe and direction (1 = write)
//   req_size                : 00 byte, 01 halfword, 10 word, 11 illegal
//   req_addr/req_wdata      : byte address and right-justified write data
//   busy                    : high whenever not idle; requests are ignored then
//   rsp_valid/rsp_fault     : one-cycle response pulse and its reject qualifier
//   rsp_rdata               : zero-extended read data, held until the next good read
module mem_responder #(
    parameter int ADDR_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        rsp_valid,
    output logic        rsp_fault,
    output logic [31:0] rsp_rdata
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_nx;
    logic [3:0] count;
    logic fault_q;
    logic [31:0] hold;
    logic [1:0] hold_off, hold_size;
    logic [31:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] widx;
    logic accept, req_fault;
    logic [3:0] be;
    logic [31:0] wlanes;
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] off, input logic [1:0] size);
        logic [31:0] s;
        s = w >> {off, 3'b000};
        return size == 2'b00 ? {24'b0, s[7:0]} : size == 2'b01 ? {16'b0, s[15:0]} : w;
    endfunction
    always_comb begin
        widx = req_addr[ADDR_WIDTH+1:2];
        req_fault = req_size == 2'b11 || (req_size == 2'b01 && req_addr[0]) ||
                    (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                    (req_addr >> (ADDR_WIDTH + 2)) != '0;
        accept = state == IDLE && req_valid && !reset;
        be = req_size == 2'b00 ? 4'b0001 << req_addr[1:0] :
             req_size == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wlanes = req_size == 2'b00 ? {4{req_wdata[7:0]}} :
                 req_size == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    end
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_nx;
    end
    // Writes, faults and single-cycle reads skip WAIT entirely.
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (req_valid ? ((req_fault || req_write || READ_LATENCY == 1) ? RESP : WAIT) : IDLE) :
                   state == WAIT ? (count == '0 ? RESP : WAIT) : IDLE;
    end
    always_comb begin
        busy = state != IDLE;
        rsp_valid = state == RESP;
        rsp_fault = state == RESP && fault_q;
    end
    // RAM is deliberately outside reset so contents survive it.
    always_ff @(posedge clock) begin
        if (accept && req_write && !req_fault)
            for (int k = 0; k < 4; k++)
                if (be[k]) mem[widx][8*k +: 8] <= wlanes[8*k +: 8];
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            fault_q <= 1'b0;
            hold <= '0;
            hold_off <= '0;
            hold_size <= '0;
            rsp_rdata <= '0;
        end else begin
            if (accept) begin
                fault_q <= req_fault;
                count <= READ_LATENCY > 1 ? 4'(READ_LATENCY - 2) : 4'd0;
                hold <= mem[widx];
                hold_off <= req_addr[1:0];
                hold_size <= req_size;
                if (!req_write && !req_fault && READ_LATENCY == 1)
                    rsp_rdata <= extract(mem[widx], req_addr[1:0], req_size);
            end
            if (state == WAIT) begin
                if (count != '0) count <= count - 4'd1;
                else rsp_rdata <= extract(hold, hold_off, hold_size);
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: scoreboard bench for mem_responder (main instance latency 2, probes at latency 1 and 5)
module tb_mem_responder;
    localparam int L = 2;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0;
    logic [1:0] req_size = 2'b10;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic busy, rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic p_valid = 1'b0, p_write = 1'b0;
    logic [1:0] p_size = 2'b10;
    logic [31:0] p_addr = '0, p_wdata = '0;
    logic b1, v1, f1, b5, v5, f5;
    logic [31:0] d1, d5;
    int checks = 0, failures = 0, cyc = 0;
    logic [31:0] last_rd = '0;
    typedef struct {logic fault; logic [31:0] rdata; int due;} exp_t;
    exp_t sb[$];

    mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(L)) dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .rsp_valid(rsp_valid), .rsp_fault(rsp_fault), .rsp_rdata(rsp_rdata));
    mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(1)) u1 (
        .clock(clock), .reset(reset), .req_valid(p_valid), .req_write(p_write),
        .req_size(p_size), .req_addr(p_addr), .req_wdata(p_wdata),
        .busy(b1), .rsp_valid(v1), .rsp_fault(f1), .rsp_rdata(d1));
    mem_responder #(.ADDR_WIDTH(8), .READ_LATENCY(5)) u5 (
        .clock(clock), .reset(reset), .req_valid(p_valid), .req_write(p_write),
        .req_size(p_size), .req_addr(p_addr), .req_wdata(p_wdata),
        .busy(b5), .rsp_valid(v5), .rsp_fault(f5), .rsp_rdata(d5));

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every response pops one expectation and checks content and arrival cycle.
    always @(negedge clock) begin
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_fault", {31'b0, rsp_fault}, {31'b0, e.fault});
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_cycle", cyc, e.due);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout: got busy=1 expected busy=0 within 50 cycles");
        end
    endtask

    task automatic issue(input logic w, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                         input logic f, input logic [31:0] rd, input bit track);
        exp_t e;
        wait_idle();
        req_valid = 1'b1;
        req_write = w;
        req_size = sz;
        req_addr = a;
        req_wdata = wd;
        if (track) begin
            e.fault = f;
            e.rdata = (w || f) ? last_rd : rd;
            e.due = cyc + 1 + ((w || f) ? 0 : L - 1);
            sb.push_back(e);
            if (!w && !f) last_rd = rd;
        end
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    initial begin
        int k1, k5, n;
        exp_t e;
        repeat (3) @(negedge clock);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_valid", {31'b0, rsp_valid}, 32'd0);
        check("reset_fault", {31'b0, rsp_fault}, 32'd0);
        check("reset_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        issue(1, 2'b10, 32'h10, 32'hDEADBEEF, 0, 0, 1);
        issue(0, 2'b10, 32'h10, 0, 0, 32'hDEADBEEF, 1);
        check("busy_wait", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check("busy_resp", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check("busy_after", {31'b0, busy}, 32'd0);
        issue(1, 2'b10, 32'h10, 32'h11223344, 0, 0, 1);
        issue(1, 2'b00, 32'h13, 32'hAAAAAA5A, 0, 0, 1);
        issue(0, 2'b10, 32'h10, 0, 0, 32'h5A223344, 1);
        issue(0, 2'b00, 32'h12, 0, 0, 32'h00000022, 1);
        issue(0, 2'b01, 32'h12, 0, 0, 32'h00005A22, 1);
        issue(1, 2'b10, 32'h14, 32'h01020304, 0, 0, 1);
        issue(1, 2'b01, 32'h16, 32'hFFFFCAFE, 0, 0, 1);
        issue(0, 2'b00, 32'h17, 0, 0, 32'h000000CA, 1);
        issue(0, 2'b00, 32'h14, 0, 0, 32'h00000004, 1);
        issue(0, 2'b10, 32'h14, 0, 0, 32'hCAFE0304, 1);
        issue(1, 2'b10, 32'h00, 32'h0BADF00D, 0, 0, 1);
        issue(0, 2'b01, 32'h11, 0, 1, 0, 1);
        issue(1, 2'b10, 32'h02, 32'h12345678, 1, 0, 1);
        issue(0, 2'b11, 32'h10, 0, 1, 0, 1);
        issue(1, 2'b11, 32'h00, 32'hFFFFFFFF, 1, 0, 1);
        issue(0, 2'b10, 32'h400, 0, 1, 0, 1);
        issue(1, 2'b10, 32'h400, 32'h55555555, 1, 0, 1);
        issue(1, 2'b00, 32'h10000000, 32'h000000EE, 1, 0, 1);
        issue(0, 2'b10, 32'h00, 0, 0, 32'h0BADF00D, 1);
        issue(0, 2'b10, 32'h10, 0, 0, 32'h5A223344, 1);
        issue(1, 2'b10, 32'h3FC, 32'h87654321, 0, 0, 1);
        issue(0, 2'b00, 32'h3FF, 0, 0, 32'h00000087, 1);
        issue(0, 2'b01, 32'h3FE, 0, 0, 32'h00008765, 1);
        // Back-to-back: req_valid stays high across two different reads.
        wait_idle();
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h10;
        e.fault = 0; e.rdata = 32'h5A223344; e.due = cyc + 2; sb.push_back(e);
        e.rdata = 32'h00000004; e.due = cyc + 5; sb.push_back(e);
        last_rd = 32'h00000004;
        @(negedge clock);
        req_size = 2'b00; req_addr = 32'h14;
        check("b2b_busy_t", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check("b2b_busy_t1", {31'b0, busy}, 32'd1);
        @(negedge clock);
        check("b2b_idle_gap", {31'b0, busy}, 32'd0);
        @(negedge clock);
        check("b2b_second_accept", {31'b0, busy}, 32'd1);
        req_valid = 1'b0;
        // Reset while the read sits in WAIT: no response, outputs cleared, RAM kept.
        issue(0, 2'b10, 32'h14, 0, 0, 0, 0);
        reset = 1'b1;
        @(negedge clock);
        check("midreset_busy", {31'b0, busy}, 32'd0);
        check("midreset_valid", {31'b0, rsp_valid}, 32'd0);
        check("midreset_fault", {31'b0, rsp_fault}, 32'd0);
        check("midreset_rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        last_rd = 32'd0;
        @(negedge clock);
        issue(0, 2'b10, 32'h14, 0, 0, 32'hCAFE0304, 1);
        issue(1, 2'b00, 32'h18, 32'h00000001, 0, 0, 1);
        // Latency sweep on the latency-1 and latency-5 instances.
        p_valid = 1'b1; p_write = 1'b1; p_size = 2'b10; p_addr = 32'h20; p_wdata = 32'h13579BDF;
        @(negedge clock);
        p_valid = 1'b0;
        check("lat_wr_v1", {31'b0, v1}, 32'd1);
        check("lat_wr_v5", {31'b0, v5}, 32'd1);
        repeat (2) @(negedge clock);
        p_valid = 1'b1; p_write = 1'b0;
        @(negedge clock);
        p_valid = 1'b0;
        k1 = -1;
        k5 = -1;
        for (int k = 0; k < 10; k++) begin
            if (v1 && k1 < 0) begin
                k1 = k;
                check("lat1_rdata", d1, 32'h13579BDF);
            end
            if (v5 && k5 < 0) begin
                k5 = k;
                check("lat5_rdata", d5, 32'h13579BDF);
            end
            @(negedge clock);
        end
        check("lat1_edges", 32'(k1 + 1), 32'd1);
        check("lat5_edges", 32'(k5 + 1), 32'd5);
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clock);
            n++;
        end
        while (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_rsp: got no response expected one due at cycle %0d", e.due);
        end
        repeat (5) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle CPU: accepts one read or write request at a time from the control/datapath side, applies byte/halfword/word lane logic against an internal word RAM, and returns a single-cycle response pulse after a fixed, parameterised read latency. It replaces fixed wait-state counting in the control unit with an explicit request/busy/response handshake.

## Interface
- `ADDR_WIDTH`, default 8. Word-index bits; RAM holds 2^ADDR_WIDTH 32-bit words. Legal byte addresses are 0 .. 4*2^ADDR_WIDTH-1.
- `READ_LATENCY`, default 2. Edges from read accept to read response; legal range 1..15.
- `clock`  in  1  Single clock; all state changes on its rising edge.
- `reset`  in  1  Synchronous, active-high.
- `req_valid`  in  1  Request present this cycle.
- `req_write`  in  1  1 = write, 0 = read.
- `req_size`  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- `req_addr`  in  32  Byte address.
- `req_wdata`  in  32  Write data, right-justified (byte in [7:0], halfword in [15:0]).
- `busy`  out  1  Responder not in IDLE; requests are ignored while high.
- `rsp_valid`  out  1  One-cycle response pulse.
- `rsp_fault`  out  1  Qualifies `rsp_valid`: request rejected, no memory effect.
- `rsp_rdata`  out  32  Read data, zero-extended, right-justified; held between responses.

## Operation
- States: IDLE, WAIT, RESP. `busy` = (state != IDLE).
- Accept: at an edge where state = IDLE and `req_valid` = 1. Request fields are sampled only at this edge.
- Fault check at accept: `req_size` = 11, or misalignment (halfword with addr[0] = 1; word with addr[1:0] != 0), or out of range (addr[31:ADDR_WIDTH+2] != 0).
  - On a fault there is no RAM access. Next state is RESP with `rsp_fault` = 1.
- Write accept (no fault): RAM is updated at the accept edge. Only the addressed lanes change.
  - Lane k = bits [8k+7:8k], selected by addr[1:0], little-endian.
  - Halfword writes lanes addr[1]*2 and addr[1]*2+1.
  - Next state is RESP with `rsp_fault` = 0.
- Read accept (no fault): the addressed word is captured into an internal holding register at the accept edge. The selected lane(s) are extracted and zero-extended.
  - If READ_LATENCY = 1, next state is RESP.
  - Otherwise, next state is WAIT with the down-counter loaded to READ_LATENCY-2.
- WAIT: while counter != 0, decrement. When counter = 0, go to RESP. `rsp_rdata` is loaded with the extracted data on this transition.
- RESP: `rsp_valid` = 1 for exactly this one cycle, then go to IDLE.
  - `rsp_rdata` is unchanged by write and fault responses.
- `rsp_rdata` holds its last value until the next successful read response.
- Reset: state IDLE, counter 0, `busy` 0, `rsp_valid` 0, `rsp_fault` 0, `rsp_rdata` 0. RAM contents are not cleared.
- Reset mid-operation (in WAIT or RESP): the transaction is abandoned and no response is issued. A write that was already accepted remains in RAM.

## Timing
- Accept at edge T.
- Read: `rsp_valid` is high in the cycle following edge T+READ_LATENCY-1. Equivalently, it is sampled high at edge T+READ_LATENCY.
- Write and fault: `rsp_valid` is high in the cycle after edge T (sampled at edge T+1).
- `busy` is high from the cycle after accept through the RESP cycle inclusive.
- The earliest next accept is the edge ending the RESP cycle's successor. In practice, one idle cycle is needed after `rsp_valid`: state returns to IDLE at the edge ending RESP, and the next accept occurs at the following edge.
- Read after write: the read observes the written data. The RAM update completes at the write accept edge, before any later read accept.
- `req_valid` held high while `busy` = 1 has no effect. The request is accepted only once state is IDLE.

## Test plan
- Word write, then read: write addr 0x10 data 0xDEADBEEF -> `rsp_valid` 1 cycle later with `rsp_fault` 0. Then read word 0x10 -> `rsp_valid` at accept+2 edges with `rsp_rdata` 0xDEADBEEF, and `busy` high for exactly those cycles.
- Lane writes and reads: byte write 0x5A to 0x13 over word 0x11223344 at 0x10.
  - Read word returns 0x5A223344.
  - Byte read of 0x12 returns 0x00000022.
  - Halfword read of 0x12 returns 0x00005A22.
- Faults, each giving `rsp_fault` 1 one cycle after accept, RAM unchanged and `rsp_rdata` unchanged:
  - halfword read at 0x11;
  - word write at 0x02;
  - `req_size` 11;
  - address 0x400 with ADDR_WIDTH 8.
- Back-to-back: `req_valid` held high with two different reads queued -> the second is accepted only after the first response plus one cycle; no lost or duplicated `rsp_valid`.
- Latency sweep: READ_LATENCY = 1, 2 and 5 -> read `rsp_valid` sampled exactly at accept+1, +2 and +5 edges respectively.
- Reset mid-read: assert `reset` in WAIT -> no `rsp_valid`, all outputs 0 next cycle. A subsequent read of the earlier-written address still returns its data (RAM preserved).
